// File: rtl/chip8_ram_arbiter_pkg.sv
// Shared encodings for the CHIP-8 RAM read-port arbiter.
package chip8_ram_arbiter_pkg;

  localparam int unsigned DEF_AW = 12;
  localparam int unsigned DEF_DW = 8;

  typedef enum logic [1:0] {
    ST_RR       = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_COOLDOWN = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_REN  = 2'd3
  } owner_t;

  typedef enum logic {
    PTR_CPU = 1'b0,
    PTR_REN = 1'b1
  } rr_ptr_t;

  typedef struct packed {
    logic vga;
    logic cpu;
    logic ren;
  } gnt_t;

endpackage

// File: rtl/chip8_prio_rr.sv
// Combinational one-hot grant encoder: vga first, locked renderer next,
// otherwise round-robin between cpu and renderer.
module chip8_prio_rr
  import chip8_ram_arbiter_pkg::*;
(
  input  logic       i_vga_req,
  input  logic       i_cpu_req,
  input  logic       i_ren_req,
  input  arb_state_t i_state,
  input  rr_ptr_t    i_ptr,
  output gnt_t       o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_vga_req) begin
      o_gnt.vga = 1'b1;
    end else if (i_state == ST_LOCKED) begin
      o_gnt.ren = i_ren_req;
    end else if (i_cpu_req && i_ren_req) begin
      if (i_ptr == PTR_CPU) o_gnt.cpu = 1'b1;
      else                  o_gnt.ren = 1'b1;
    end else begin
      o_gnt.cpu = i_cpu_req;
      o_gnt.ren = i_ren_req;
    end
  end

endmodule

// File: rtl/chip8_ram_arbiter.sv
// Three-port read arbiter for chip8_ram with renderer burst locking and
// fixed one-cycle read latency tracked by a registered owner field.
module chip8_ram_arbiter
  import chip8_ram_arbiter_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_rvalid,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  input  logic          ren_req,
  input  logic          ren_lock,
  input  logic [AW-1:0] ren_addr,
  output logic          ren_gnt,
  output logic          ren_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_q
);

  localparam int unsigned  CW      = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

  arb_state_t    r_state, w_state_nxt;
  rr_ptr_t       r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_lock_cnt, w_lock_cnt_nxt;
  owner_t        r_owner, w_owner_nxt;
  logic [AW-1:0] r_raddr, w_raddr_nxt;
  gnt_t          w_gnt_raw;
  gnt_t          w_gnt;

  chip8_prio_rr u_prio (
    .i_vga_req (vga_req),
    .i_cpu_req (cpu_req),
    .i_ren_req (ren_req),
    .i_state   (r_state),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt_raw)
  );

  // Grants are suppressed while reset is high so no request is consumed.
  assign w_gnt = reset ? '0 : w_gnt_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RR;
      r_ptr      <= PTR_CPU;
      r_lock_cnt <= '0;
      r_owner    <= OWN_NONE;
      r_raddr    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_owner    <= w_owner_nxt;
      r_raddr    <= w_raddr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_lock_cnt_nxt = r_lock_cnt;
    w_owner_nxt    = OWN_NONE;
    w_raddr_nxt    = r_raddr;

    if (w_gnt.vga) begin
      w_owner_nxt = OWN_VGA;
      w_raddr_nxt = vga_addr;
    end else if (w_gnt.cpu) begin
      w_owner_nxt = OWN_CPU;
      w_raddr_nxt = cpu_addr;
      w_ptr_nxt   = PTR_REN;
    end else if (w_gnt.ren) begin
      w_owner_nxt = OWN_REN;
      w_raddr_nxt = ren_addr;
      w_ptr_nxt   = PTR_CPU;
    end

    case (r_state)
      ST_RR: begin
        if (w_gnt.ren && ren_lock) begin
          if (LOCK_MAX <= 1) begin
            w_state_nxt    = ST_COOLDOWN;
            w_lock_cnt_nxt = '0;
          end else begin
            w_state_nxt    = ST_LOCKED;
            w_lock_cnt_nxt = CW'(1);
          end
        end
      end
      ST_LOCKED: begin
        // A dropped lock wins over a simultaneous terminal-count grant.
        if (!ren_lock) begin
          w_state_nxt    = ST_RR;
          w_ptr_nxt      = PTR_CPU;
          w_lock_cnt_nxt = '0;
        end else if (w_gnt.ren) begin
          if (r_lock_cnt >= CNT_MAX - CW'(1)) begin
            w_state_nxt    = ST_COOLDOWN;
            w_ptr_nxt      = PTR_CPU;
            w_lock_cnt_nxt = '0;
          end else begin
            w_lock_cnt_nxt = (r_lock_cnt == CNT_MAX) ? CNT_MAX : r_lock_cnt + CW'(1);
          end
        end
      end
      ST_COOLDOWN: begin
        if (!ren_lock) w_state_nxt = ST_RR;
      end
      default: begin
        w_state_nxt    = ST_RR;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    vga_gnt    = w_gnt.vga;
    cpu_gnt    = w_gnt.cpu;
    ren_gnt    = w_gnt.ren;
    vga_rvalid = !reset && (r_owner == OWN_VGA);
    cpu_rvalid = !reset && (r_owner == OWN_CPU);
    ren_rvalid = !reset && (r_owner == OWN_REN);
    rdata      = ram_q;
    ram_raddr  = reset ? '0 : w_raddr_nxt;
  end

endmodule

// File: tb/tb_chip8_ram_arbiter.sv
// Directed bench for chip8_ram_arbiter with a behavioural one-cycle RAM.
module tb_chip8_ram_arbiter;
  import chip8_ram_arbiter_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vga_req, cpu_req, ren_req, ren_lock;
  logic [AW-1:0] vga_addr, cpu_addr, ren_addr;
  logic          vga_gnt, cpu_gnt, ren_gnt;
  logic          vga_rvalid, cpu_rvalid, ren_rvalid;
  logic [DW-1:0] rdata, ram_q;
  logic [AW-1:0] ram_raddr;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int            n_checks = 0;
  int            n_errors = 0;
  logic [2:0]    exp_prev = 3'b000;
  logic [AW-1:0] prev_addr = '0;
  logic [AW-1:0] exp_hold = '0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_raddr];

  chip8_ram_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_gnt    (vga_gnt),
    .vga_rvalid (vga_rvalid),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .ren_req    (ren_req),
    .ren_lock   (ren_lock),
    .ren_addr   (ren_addr),
    .ren_gnt    (ren_gnt),
    .ren_rvalid (ren_rvalid),
    .rdata      (rdata),
    .ram_raddr  (ram_raddr),
    .ram_q      (ram_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: exp_g is the expected {vga,cpu,ren} grant this cycle.
  task automatic step(input string tag, input logic [2:0] exp_g);
    logic [AW-1:0] a;
    @(negedge clk);
    check({tag, " gnt"}, 32'({vga_gnt, cpu_gnt, ren_gnt}), 32'(exp_g));
    check({tag, " rvalid"}, 32'({vga_rvalid, cpu_rvalid, ren_rvalid}),
          reset ? 32'(0) : 32'(exp_prev));
    if (!reset && exp_prev != 3'b000)
      check({tag, " rdata"}, 32'(rdata), 32'(mem[prev_addr]));
    a = exp_g[2] ? vga_addr : (exp_g[1] ? cpu_addr : ren_addr);
    if (reset) exp_hold = '0;
    else if (exp_g != 3'b000) exp_hold = a;
    check({tag, " raddr"}, 32'(ram_raddr), 32'(exp_hold));
    exp_prev  = reset ? 3'b000 : exp_g;
    prev_addr = a;
    @(posedge clk);
    #1;
  endtask

  // Requests are held high during reset to show they are masked.
  task automatic do_reset(input string tag);
    reset = 1'b1; vga_req = 1'b0; cpu_req = 1'b1; ren_req = 1'b1; ren_lock = 1'b1;
    step({tag, " rst0"}, 3'b000);
    step({tag, " rst1"}, 3'b000);
    check({tag, " rst st"}, 32'(dut.r_state), 32'(ST_RR));
    check({tag, " rst cnt"}, 32'(dut.r_lock_cnt), 32'(0));
    reset = 1'b0; cpu_req = 1'b0; ren_req = 1'b0; ren_lock = 1'b0;
  endtask

  localparam logic [2:0] G_NONE = 3'b000;
  localparam logic [2:0] G_VGA  = 3'b100;
  localparam logic [2:0] G_CPU  = 3'b010;
  localparam logic [2:0] G_REN  = 3'b001;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'((i * 37 + 5) ^ (i >> 4));
    vga_addr = 12'h789; cpu_addr = 12'h123; ren_addr = 12'h456;

    // Alternation from reset, then a vga request in cycle 5.
    do_reset("alt");
    cpu_req = 1'b1; ren_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step($sformatf("alt c%0d", c), (c % 2 == 0) ? G_CPU : G_REN);
      if (c % 2 == 0) cpu_addr = cpu_addr + 12'd1;
      else            ren_addr = ren_addr + 12'd1;
    end
    vga_req = 1'b1;
    step("alt c5 vga", G_VGA);
    check("alt ptr after vga", 32'(dut.r_ptr), 32'(PTR_REN));
    vga_req = 1'b0;
    step("alt c6", G_REN);
    step("alt c7", G_CPU);

    // Full 16-grant burst, then cooldown alternation.
    do_reset("burst");
    cpu_req = 1'b1; ren_req = 1'b1; ren_lock = 1'b1;
    step("burst c0", G_CPU);
    for (int i = 0; i < 16; i++) step($sformatf("burst ren%0d", i), G_REN);
    check("burst st cd", 32'(dut.r_state), 32'(ST_COOLDOWN));
    for (int i = 0; i < 4; i++) step($sformatf("cd c%0d", i), (i % 2 == 0) ? G_CPU : G_REN);
    check("cd st hold", 32'(dut.r_state), 32'(ST_COOLDOWN));
    ren_lock = 1'b0;
    step("cd exit", G_CPU);
    check("cd st rr", 32'(dut.r_state), 32'(ST_RR));

    // Lock dropped after 5 locked grants.
    do_reset("drop");
    cpu_req = 1'b1; ren_req = 1'b1; ren_lock = 1'b1;
    step("drop c0", G_CPU);
    for (int i = 0; i < 5; i++) step($sformatf("drop ren%0d", i), G_REN);
    check("drop cnt5", 32'(dut.r_lock_cnt), 32'(5));
    ren_lock = 1'b0; ren_req = 1'b0;
    step("drop idle", G_NONE);
    check("drop st rr", 32'(dut.r_state), 32'(ST_RR));
    ren_req = 1'b1;
    step("drop cpu", G_CPU);
    step("drop ren", G_REN);
    check("drop st stay", 32'(dut.r_state), 32'(ST_RR));

    // vga pulse in the middle of a burst.
    do_reset("vgab");
    cpu_req = 1'b1; ren_req = 1'b1; ren_lock = 1'b1;
    step("vgab c0", G_CPU);
    step("vgab r1", G_REN);
    step("vgab r2", G_REN);
    vga_req = 1'b1;
    step("vgab vga", G_VGA);
    check("vgab cnt", 32'(dut.r_lock_cnt), 32'(2));
    check("vgab st", 32'(dut.r_state), 32'(ST_LOCKED));
    vga_req = 1'b0;
    for (int i = 0; i < 14; i++) step($sformatf("vgab ren%0d", i + 3), G_REN);
    check("vgab st cd", 32'(dut.r_state), 32'(ST_COOLDOWN));
    step("vgab cpu", G_CPU);

    // Reset in the middle of a burst skips cooldown.
    do_reset("mrst");
    cpu_req = 1'b1; ren_req = 1'b1; ren_lock = 1'b1;
    step("mrst c0", G_CPU);
    step("mrst r1", G_REN);
    step("mrst r2", G_REN);
    do_reset("mrst2");
    cpu_req = 1'b1; ren_req = 1'b1; ren_lock = 1'b1;
    step("mrst2 c0", G_CPU);
    step("mrst2 r1", G_REN);
    check("mrst2 st", 32'(dut.r_state), 32'(ST_LOCKED));
    check("mrst2 cnt", 32'(dut.r_lock_cnt), 32'(1));

    // Reset the cycle after a cpu grant.
    do_reset("rg");
    cpu_addr = 12'hABC;
    cpu_req = 1'b1;
    step("rg cpu", G_CPU);
    reset = 1'b1; cpu_req = 1'b0;
    step("rg rst0", G_NONE);
    step("rg rst1", G_NONE);
    reset = 1'b0;
    step("rg idle0", G_NONE);
    step("rg idle1", G_NONE);
    cpu_req = 1'b1;
    step("rg new", G_CPU);
    cpu_req = 1'b0;
    step("rg tail", G_NONE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
